// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares the single-port data memory between the CPU load/store path and the
// host loader/debug port. At most one access is issued per clock. Contention
// is round-robin with a bounded host burst allowance. Read data is steered back
// to the issuing port RD_LAT cycles after its grant.
//
// Ports
//   clk, reset                      clock, asynchronous active-low reset
//   cpu_req/wr/addr/wdata    (in)   CPU access request
//   cpu_gnt/rvalid/rdata     (out)  CPU grant and read return
//   host_req/wr/addr/wdata   (in)   host access request
//   host_gnt/rvalid/rdata    (out)  host grant and read return
//   mem_addr/wdata/wr/rd     (out)  memory bus
//   mem_rdata                (in)   memory read data, RD_LAT cycles after mem_rd
//
// Arbitration state
//   last_gnt | meaning
//   GNT_CPU  | last grant went to the CPU; host wins the next contention
//   GNT_HOST | last grant went to the host; host keeps winning until host_run = BURST_MAX
module dmem_arbiter #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 16,
    parameter int RD_LAT    = 1,
    parameter int BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              host_req,
    input  logic              host_wr,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata
);
    // BURST_MAX is at most 15, so a 4-bit run counter always suffices.
    localparam int                RUN_W     = 4;
    localparam logic [RUN_W-1:0] BURST_CAP = RUN_W'(BURST_MAX);

    typedef enum logic {
        GNT_CPU  = 1'b0,
        GNT_HOST = 1'b1
    } gnt_src_e;

    gnt_src_e          last_gnt, last_gnt_nxt;
    logic [RUN_W-1:0]  host_run, host_run_nxt;
    logic              cpu_win, host_win;
    logic [RD_LAT-1:0] tag_vld;
    logic [RD_LAT-1:0] tag_host;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_gnt <= GNT_HOST;
            host_run <= BURST_CAP;
        end else begin
            last_gnt <= last_gnt_nxt;
            host_run <= host_run_nxt;
        end
    end

    // Grant is combinational so a request can be served in the cycle it rises.
    // Holding reset low suppresses every grant regardless of the requests.
    always_comb begin
        cpu_win  = 1'b0;
        host_win = 1'b0;
        if (reset) begin
            if (cpu_req && host_req) begin
                if (last_gnt == GNT_HOST && host_run >= BURST_CAP)
                    cpu_win = 1'b1;
                else
                    host_win = 1'b1;
            end else begin
                cpu_win  = cpu_req;
                host_win = host_req;
            end
        end
    end

    // A CPU grant or an idle cycle ends the host burst.
    always_comb begin
        last_gnt_nxt = last_gnt;
        host_run_nxt = '0;
        if (cpu_win) begin
            last_gnt_nxt = GNT_CPU;
        end else if (host_win) begin
            last_gnt_nxt = GNT_HOST;
            host_run_nxt = (host_run >= BURST_CAP) ? BURST_CAP : host_run + RUN_W'(1);
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wr    = 1'b0;
        mem_rd    = 1'b0;
        if (cpu_win) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_wr    = cpu_wr;
            mem_rd    = ~cpu_wr;
        end else if (host_win) begin
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
            mem_wr    = host_wr;
            mem_rd    = ~host_wr;
        end
    end

    // Read tags travel alongside the memory latency; stage RD_LAT-1 lines up
    // with valid mem_rdata, which keeps returns in issue order.
    if (RD_LAT == 1) begin : g_tag_lat1
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                tag_vld  <= '0;
                tag_host <= '0;
            end else begin
                tag_vld  <= mem_rd;
                tag_host <= host_win;
            end
        end
    end else begin : g_tag_latn
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                tag_vld  <= '0;
                tag_host <= '0;
            end else begin
                tag_vld  <= {tag_vld[RD_LAT-2:0], mem_rd};
                tag_host <= {tag_host[RD_LAT-2:0], host_win};
            end
        end
    end

    assign cpu_gnt     = cpu_win;
    assign host_gnt    = host_win;
    assign cpu_rvalid  = reset & tag_vld[RD_LAT-1] & ~tag_host[RD_LAT-1];
    assign host_rvalid = reset & tag_vld[RD_LAT-1] &  tag_host[RD_LAT-1];
    assign cpu_rdata   = mem_rdata;
    assign host_rdata  = mem_rdata;

endmodule
